// File: rtl/spi_flash_responder_if.sv
// SPI pin and byte-wide memory port bundle for the flash responder.
// The slave modport is the responder side; master is the controller/memory side.
interface spi_flash_responder_if;
  logic        SPI_CSN;
  logic        SPI_CLK;
  logic        SPI_MOSI;
  logic        SPI_MISO;
  logic        SPI_MISO_OE;
  logic        MEM_RD;
  logic [23:0] MEM_ADDR;
  logic [7:0]  MEM_RDATA;

  modport slave (
    input  SPI_CSN, SPI_CLK, SPI_MOSI, MEM_RDATA,
    output SPI_MISO, SPI_MISO_OE, MEM_RD, MEM_ADDR
  );

  modport master (
    output SPI_CSN, SPI_CLK, SPI_MOSI, MEM_RDATA,
    input  SPI_MISO, SPI_MISO_OE, MEM_RD, MEM_ADDR
  );
endinterface

// File: rtl/spi_flash_responder.sv
// Serial-flash target emulator: oversampled SPI mode 0, commands 03/9F/05 served from a byte memory port.
// Optional fast read (0x0B with 8 dummy clocks) is built when FLASH_RESP_FAST_READ_EN is defined.
module spi_flash_responder #(
  parameter logic [23:0] JEDEC_ID   = 24'hEF4016,
  parameter logic [7:0]  STATUS_VAL = 8'h00
) (
  input  logic                        CLK,
  input  logic                        RSTN,
  spi_flash_responder_if.slave        bus,
  output logic                        BUSY,
  output logic                        CMD_ERR
);

`ifdef FLASH_RESP_FAST_READ_EN
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_t;
`else
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;
`endif

  typedef enum logic [1:0] {SRC_MEM, SRC_JEDEC, SRC_STATUS} src_t;

  state_t      state;
  src_t        src;
  logic [4:0]  bit_cnt;
  logic [2:0]  tx_bit;
  logic [1:0]  jedec_idx;
  logic        rd_pend;
  logic        rd_dst;
`ifdef FLASH_RESP_FAST_READ_EN
  logic        fast;
`endif

  logic        csn_s1, csn_s2, csn_d;
  logic        sclk_s1, sclk_s2, sclk_d;
  logic        mosi_s1, mosi_s2;

  logic        miso, miso_oe, mem_rd, busy, cmd_err;
  logic [23:0] mem_addr;

  logic [22:0] rx_shift;
  logic [7:0]  tx_shift;
  logic [7:0]  hold;

  logic        csn_fall, rise_ev, fall_ev, tx_fall, rd_valid, cmd_done;
  logic [23:0] rx_next;
  logic [7:0]  opcode;
  logic [1:0]  jedec_nxt;

  function automatic logic [7:0] jedec_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return JEDEC_ID[23:16];
      2'd1:    return JEDEC_ID[15:8];
      default: return JEDEC_ID[7:0];
    endcase
  endfunction

  // Stage: pin synchronizers plus one delay tap for edge detection
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      {csn_s1, csn_s2, csn_d}    <= 3'b111;
      {sclk_s1, sclk_s2, sclk_d} <= 3'b000;
      {mosi_s1, mosi_s2}         <= 2'b00;
    end else begin
      {csn_s1, csn_s2, csn_d}    <= {bus.SPI_CSN, csn_s1, csn_s2};
      {sclk_s1, sclk_s2, sclk_d} <= {bus.SPI_CLK, sclk_s1, sclk_s2};
      {mosi_s1, mosi_s2}         <= {bus.SPI_MOSI, mosi_s1};
    end
  end

  // SPI clock edges are suppressed whenever CSN is high, so a CSN rise beats a coincident edge
  assign csn_fall  = ~csn_s2 & csn_d;
  assign rise_ev   = ~csn_s2 & sclk_s2 & ~sclk_d;
  assign fall_ev   = ~csn_s2 & ~sclk_s2 & sclk_d;
  assign rx_next   = {rx_shift, mosi_s2};
  assign opcode    = rx_next[7:0];
  assign tx_fall   = fall_ev && (state == DATA);
  assign rd_valid  = rd_pend && (state == DATA) && ~csn_s2;
  assign cmd_done  = rise_ev && (state == CMD) && (bit_cnt == 5'd7);
  assign jedec_nxt = (jedec_idx == 2'd2) ? 2'd0 : jedec_idx + 2'd1;

  // Stage: shift/holding datapath, no reset needed (cleared or loaded before use)
  always_ff @(posedge CLK) begin
    if (state == IDLE && csn_fall)
      rx_shift <= '0;
    else if (rise_ev && (state == CMD || state == ADDR))
      rx_shift <= rx_next[22:0];

    if (cmd_done && opcode == 8'h9F)
      tx_shift <= jedec_byte(2'd0);
    else if (cmd_done && opcode == 8'h05)
      tx_shift <= STATUS_VAL;
    else if (rd_valid && !rd_dst)
      tx_shift <= bus.MEM_RDATA;
    else if (tx_fall)
      tx_shift <= (tx_bit == 3'd7) ? hold : {tx_shift[6:0], 1'b0};

    if (rd_valid && rd_dst)
      hold <= bus.MEM_RDATA;
    else if (tx_fall && tx_bit == 3'd0) begin
      if (src == SRC_JEDEC)
        hold <= jedec_byte(jedec_nxt);
      else if (src == SRC_STATUS)
        hold <= STATUS_VAL;
    end
  end

  // Stage: control FSM with registered pin and memory-port outputs
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      src       <= SRC_MEM;
      bit_cnt   <= '0;
      tx_bit    <= '0;
      jedec_idx <= '0;
      rd_pend   <= 1'b0;
      rd_dst    <= 1'b0;
`ifdef FLASH_RESP_FAST_READ_EN
      fast      <= 1'b0;
`endif
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      mem_rd  <= 1'b0;
      cmd_err <= 1'b0;
      busy    <= ~csn_s2;
      rd_pend <= mem_rd;
      if (csn_s2) begin
        state   <= IDLE;
        miso_oe <= 1'b0;
        miso    <= 1'b0;
        rd_pend <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (csn_d) begin
              state   <= CMD;
              bit_cnt <= '0;
            end
          end
          CMD: begin
            if (rise_ev) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                case (opcode)
                  8'h03: begin
                    state <= ADDR;
`ifdef FLASH_RESP_FAST_READ_EN
                    fast  <= 1'b0;
`endif
                  end
`ifdef FLASH_RESP_FAST_READ_EN
                  8'h0B: begin
                    state <= ADDR;
                    fast  <= 1'b1;
                  end
`endif
                  8'h9F: begin
                    state     <= DATA;
                    src       <= SRC_JEDEC;
                    jedec_idx <= 2'd0;
                    tx_bit    <= '0;
                    miso_oe   <= 1'b1;
                  end
                  8'h05: begin
                    state   <= DATA;
                    src     <= SRC_STATUS;
                    tx_bit  <= '0;
                    miso_oe <= 1'b1;
                  end
                  default: begin
                    state   <= IGNORE;
                    cmd_err <= 1'b1;
                  end
                endcase
              end
            end
          end
          ADDR: begin
            if (rise_ev) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd23) begin
                bit_cnt  <= '0;
                mem_addr <= rx_next;
                mem_rd   <= 1'b1;
                rd_dst   <= 1'b0;
                src      <= SRC_MEM;
                tx_bit   <= '0;
                miso_oe  <= 1'b1;
                state    <= DATA;
`ifdef FLASH_RESP_FAST_READ_EN
                // fast read parks the address and defers the fetch until the dummy phase ends
                if (fast) begin
                  mem_rd  <= 1'b0;
                  miso_oe <= 1'b0;
                  state   <= DUMMY;
                end
`endif
              end
            end
          end
`ifdef FLASH_RESP_FAST_READ_EN
          DUMMY: begin
            if (rise_ev) begin
              bit_cnt <= bit_cnt + 5'd1;
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                mem_rd  <= 1'b1;
                rd_dst  <= 1'b0;
                src     <= SRC_MEM;
                tx_bit  <= '0;
                miso_oe <= 1'b1;
                state   <= DATA;
              end
            end
          end
`endif
          DATA: begin
            if (fall_ev) begin
              miso   <= tx_shift[7];
              tx_bit <= tx_bit + 3'd1;
              // first bit of a byte on the wire: fetch the following byte into the holding register
              if (tx_bit == 3'd0) begin
                case (src)
                  SRC_MEM: begin
                    mem_rd   <= 1'b1;
                    mem_addr <= mem_addr + 24'd1;
                    rd_dst   <= 1'b1;
                  end
                  SRC_JEDEC: jedec_idx <= jedec_nxt;
                  default: ;
                endcase
              end
            end
          end
          IGNORE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.SPI_MISO    = miso;
  assign bus.SPI_MISO_OE = miso_oe;
  assign bus.MEM_RD      = mem_rd;
  assign bus.MEM_ADDR    = mem_addr;
  assign BUSY            = busy;
  assign CMD_ERR         = cmd_err;

endmodule
